fxp_dot_mac: RTL
================

# fxp_dot_mac

Streaming signed fixed-point dot-product engine, the successor to the single-step MAC tile. It accepts K operand pairs (a, x) over a valid/ready handshake and forms each product with the shift-add multiplier. Products accumulate in a guard-bit-extended register, and one N-bit result per vector is returned over a second valid/ready handshake. It sits between operand buffers and the result consumer in the datapath.

## Interface
- N, 8: operand and result width, signed two's complement; N ≥ 2, even.
- K, 4: products per vector (dot-product length); K ≥ 1.
- FRAC, N-1: fractional bits of a, x and y (default is Q1.(N-1)); 0 ≤ FRAC ≤ 2N-2.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operand pair present.
- in_ready  out  1  engine accepts a pair this cycle.
- a  in  N  signed multiplicand.
- x  in  N  signed multiplier.
- out_valid  out  1  result y valid.
- out_ready  in  1  consumer takes y.
- y  out  N  signed dot-product result.
- ovf  out  1  result was clamped; see Configuration.
- busy  out  1  vector in progress (state ≠ IDLE).

## Operation
- Pair accepted when in_valid && in_ready at a rising edge.
- Product: p = (a·x) as a full 2N-bit signed value, then arithmetic shift right by FRAC. This truncates toward −∞.
- ACC_W = 2N + clog2(K) + 1. The accumulator sign-extends p and never overflows internally.
- FSM states: IDLE, ACC, DRAIN, OUT.
  - IDLE: in_ready=1, acc=0, cnt=0. An accepted pair goes to ACC, or to DRAIN if K=1.
  - ACC: in_ready=1. Each accepted pair increments cnt. The K-th accepted pair goes to DRAIN.
  - DRAIN: in_ready=0. The final product is added and y is loaded. Always exactly one cycle, then OUT.
  - OUT: in_ready=0, out_valid=1, y and ovf held stable. On out_ready the FSM goes to IDLE and clears acc and cnt.
- Stage 1 is the product register p_r with p_v. It loads on acceptance; p_v=0 otherwise.
- Stage 2: acc <= acc + p_r when p_v. In DRAIN, y and ovf load from the narrowed acc + p_r.
- Narrowing acc to N bits is governed by the Configuration macro.
- Gaps in in_valid are allowed. cnt counts only accepted pairs.

## Timing
- Reset values: in_ready=0 while rst is high, 1 in the first cycle after release. out_valid=0, y=0, ovf=0, busy=0. acc, cnt, p_r and p_v are all 0.
- Latency: the K-th pair is accepted at edge E. y and out_valid are visible after edge E+1.
- Throughput: one pair per cycle within a vector. Per-vector overhead is 1 DRAIN cycle plus at least 1 OUT cycle.
- in_ready is a registered function of state only; it does not depend combinationally on in_valid.
- Backpressure: y, ovf and out_valid hold unchanged in OUT until out_ready. out_ready outside OUT is ignored.
- An out_ready handshake returns the FSM to IDLE. in_ready is 1 in the next cycle; no same-cycle overlap with the next vector.
- Reset mid-vector: the partial sum and any pending product are discarded. All registers return to reset values immediately.

## Configuration
- MAC_SAT_EN defined: y is clamped to [−2^(N−1), 2^(N−1)−1]. ovf=1 when clamping occurred, and is held with y.
- MAC_SAT_EN undefined: y = acc[N−1:0], i.e. wrap-around. ovf is tied to 0 and the saturation logic is absent.

## Structure
- fxp_mac_pkg holds:
  - state enum {IDLE, ACC, DRAIN, OUT};
  - localparam helper acc_w(N,K);
  - function sat_narrow.
- Sub-module fxp_mult (N, FRAC):
  - combinational shift-add radix-4 array built from the existing adder;
  - outputs the 2N-bit product shifted by FRAC.
- The top level holds the FSM, counter, pipeline registers and output register.

## Test plan
- N=8, K=4, FRAC=7, four pairs a=x=0x40: each p=0x20, sum 128. With MAC_SAT_EN, y=0x7F and ovf=1; without, y=0x80.
- K=1, a=x=0x80 (−1·−1): p=128. With MAC_SAT_EN, y=0x7F and ovf=1. Separately, a=0xFF, x=0x01 gives y=0xFF (truncation toward −∞).
- K=4, pairs (0x20,0x40),(0xE0,0x40),(0x10,0x10),(0x00,0x7F): y=0x02, ovf=0. in_valid gaps of 0–3 cycles give an identical y.
- Hold out_ready=0 for 5 cycles in OUT: y stable, out_valid=1, in_ready=0. Release: IDLE next cycle, next vector accepted.
- Assert rst after 2 of 4 pairs, then send a fresh vector: the result excludes the discarded partials, and outputs read 0 during reset.

Source files
------------

// File: rtl/fxp_mac_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fxp_mac_pkg
// Description : Shared types and helpers for the fixed-point dot-product
//               engine: FSM state encoding, accumulator width helper and
//               the saturating narrowing function.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package fxp_mac_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_e;

  // Width of the saturation working value; accumulators up to this width are supported.
  localparam int SAT_W = 64;

  // Accumulator width: full product plus enough guard bits for K terms and a sign.
  function automatic int acc_w(input int n, input int k);
    return 2 * n + $clog2(k) + 1;
  endfunction

  // Clamp a wide signed value into an n-bit signed range.
  // Returns {clamped_flag, clamped_value}; the caller keeps the low n bits.
  function automatic logic [SAT_W:0] sat_narrow(input logic signed [SAT_W-1:0] v,
                                                input int n);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (64'sd1 <<< (n - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (n - 1));
    if (v > hi) return {1'b1, hi};
    if (v < lo) return {1'b1, lo};
    return {1'b0, v};
  endfunction

endpackage
`default_nettype wire

// File: rtl/fxp_dot_mac_mult.sv
`default_nettype none
// ============================================================================
// Module      : fxp_mult
// Description : Combinational signed N x N radix-4 (Booth) shift-add
//               multiplier. Produces the full 2N-bit product and applies an
//               arithmetic right shift by FRAC (truncation toward -inf).
// Ports       : a_i [N-1:0]  signed multiplicand
//               x_i [N-1:0]  signed multiplier (recoded into N/2 digits)
//               p_o [2N-1:0] product >>> FRAC
// Revision    : 1.0 - initial release
// ============================================================================
module fxp_mult #(
  parameter int N    = 8,
  parameter int FRAC = N - 1
) (
  input  logic [N-1:0]   a_i,
  input  logic [N-1:0]   x_i,
  output logic [2*N-1:0] p_o
);

  localparam int W      = 2 * N;
  localparam int DIGITS = N / 2;

  logic [W-1:0]        w_a_ext;
  logic [W-1:0]        w_part [0:DIGITS];
  logic signed [W-1:0] w_prod;

  assign w_a_ext  = {{N{a_i[N-1]}}, a_i};
  assign w_part[0] = '0;

  genvar gi;
  for (gi = 0; gi < DIGITS; gi++) begin : g_digit
    logic [2:0]   w_trip;
    logic [W-1:0] w_pp;

    // Booth triplet {x[2i+1], x[2i], x[2i-1]}, with an implicit 0 below bit 0.
    if (gi == 0) begin : g_lsb
      assign w_trip = {x_i[1], x_i[0], 1'b0};
    end else begin : g_upper
      assign w_trip = x_i[2*gi+1 : 2*gi-1];
    end

    always_comb begin
      case (w_trip)
        3'b001, 3'b010: w_pp = w_a_ext;
        3'b011:         w_pp = w_a_ext << 1;
        3'b100:         w_pp = -(w_a_ext << 1);
        3'b101, 3'b110: w_pp = -w_a_ext;
        default:        w_pp = '0;
      endcase
    end

    // Modulo-2^W addition is exact here: the true product always fits in W bits.
    assign w_part[gi+1] = w_part[gi] + (w_pp << (2 * gi));
  end

  assign w_prod = w_part[DIGITS];
  assign p_o    = w_prod >>> FRAC;

endmodule
`default_nettype wire

// File: rtl/fxp_dot_mac.sv
`default_nettype none
// ============================================================================
// Module      : fxp_dot_mac
// Description : Streaming signed fixed-point dot-product engine. Accepts K
//               (a, x) pairs, accumulates (a*x)>>>FRAC in a guard-extended
//               register and returns one N-bit result per vector.
//               Optional macro MAC_SAT_EN selects saturating narrowing with
//               an overflow flag; otherwise the result wraps and ovf is 0.
// Ports       : clk, rst (async, active-high)
//               in_valid/in_ready, a, x   operand pair handshake
//               out_valid/out_ready, y    result handshake
//               ovf                       result was clamped
//               busy                      vector in progress
// Revision    : 1.0 - initial release
// ============================================================================
module fxp_dot_mac
  import fxp_mac_pkg::*;
#(
  parameter int N    = 8,
  parameter int K    = 4,
  parameter int FRAC = N - 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] x,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] y,
  output logic         ovf,
  output logic         busy
);

  localparam int ACC_W = acc_w(N, K);
  localparam int CNT_W = $clog2(K + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(K - 1);

  state_e                   state_q, state_d;
  logic                     in_ready_q, in_ready_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [2*N-1:0]           p_q;
  logic                     p_v_q;
  logic [N-1:0]             y_q, y_d;
  logic                     ovf_q, ovf_d;

  logic                     w_accept;
  logic [2*N-1:0]           w_prod;
  logic signed [ACC_W-1:0]  w_sum;
  logic [N-1:0]             w_y;
  logic                     w_ovf;

  fxp_mult #(
    .N    (N),
    .FRAC (FRAC)
  ) u_mult (
    .a_i (a),
    .x_i (x),
    .p_o (w_prod)
  );

  assign w_accept = in_valid && in_ready_q;
  assign w_sum    = acc_q + {{(ACC_W - 2*N){p_q[2*N-1]}}, p_q};

`ifdef MAC_SAT_EN
  assign w_y   = N'(sat_narrow(SAT_W'(w_sum), N));
  assign w_ovf = 1'(sat_narrow(SAT_W'(w_sum), N) >> SAT_W);
`else
  assign w_y   = w_sum[N-1:0];
  assign w_ovf = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and datapath next values
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    y_d     = y_q;
    ovf_d   = ovf_q;

    if (p_v_q) acc_d = w_sum;

    case (state_q)
      IDLE: begin
        if (w_accept) begin
          cnt_d   = CNT_W'(1);
          state_d = (K == 1) ? DRAIN : ACC;
        end
      end
      ACC: begin
        if (w_accept) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // The last product is still in p_q; fold it in while narrowing.
        y_d     = w_y;
        ovf_d   = w_ovf;
        state_d = OUT;
      end
      OUT: begin
        if (out_ready) begin
          state_d = IDLE;
          cnt_d   = '0;
          acc_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Registered from the next state so in_ready never sees in_valid combinationally.
    in_ready_d = (state_d == IDLE) || (state_d == ACC);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready_q <= 1'b0;
      cnt_q      <= '0;
      acc_q      <= '0;
      p_q        <= '0;
      p_v_q      <= 1'b0;
      y_q        <= '0;
      ovf_q      <= 1'b0;
    end else begin
      in_ready_q <= in_ready_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      if (w_accept) p_q <= w_prod;
      p_v_q      <= w_accept;
      y_q        <= y_d;
      ovf_q      <= ovf_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q == OUT);
  assign busy      = (state_q != IDLE);
  assign y         = y_q;
  assign ovf       = ovf_q;

endmodule
`default_nettype wire
